// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle RV32M multiply/divide sequencer (shift-add multiply,
//            restoring divide, sign fix-up, one-cycle result strobe).
// Revision : 1.0
// ============================================================================
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start_EX,
    input  logic [2:0]       i_op_EX,
    input  logic [WIDTH-1:0] i_rd1_EX,
    input  logic [WIDTH-1:0] i_rd2_EX,
    input  logic             i_kill_EX,
    output logic             o_busy_EX,
    output logic             o_valid_EX,
    output logic [WIDTH-1:0] o_result_EX
);

    localparam int                 c_CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_CALC = 2'd1;
    localparam logic [1:0] c_S_FIX  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    localparam logic [2:0] c_OP_MUL    = 3'd0;
    localparam logic [2:0] c_OP_MULH   = 3'd1;
    localparam logic [2:0] c_OP_MULHSU = 3'd2;
    localparam logic [2:0] c_OP_MULHU  = 3'd3;
    localparam logic [2:0] c_OP_DIV    = 3'd4;
    localparam logic [2:0] c_OP_DIVU   = 3'd5;
    localparam logic [2:0] c_OP_REM    = 3'd6;

    logic [1:0]           state_q,  state_d;
    logic [c_CNT_W-1:0]   cnt_q,    cnt_d;
    logic [2:0]           op_q,     op_d;
    logic                 neg_q,    neg_d;
    logic [2*WIDTH-1:0]   acc_q,    acc_d;
    logic [WIDTH-1:0]     opnd_q,   opnd_d;
    logic [WIDTH-1:0]     result_q, result_d;

    logic                 rs1_signed, rs2_signed;
    logic                 sign1, sign2, start_neg;
    logic [WIDTH-1:0]     mag1, mag2;
    logic                 div_by_zero, div_ovf, fast_path;
    logic [WIDTH-1:0]     fast_result;
    logic                 start_ok;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_step;
    logic [WIDTH:0]       div_diff;
    logic [2*WIDTH-1:0]   div_step;

    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_raw, rem_raw, quot_fix, rem_fix;
    logic [WIDTH-1:0]     fix_result;

    // ------------------------------------------------------------------
    // Operand decode at launch
    // ------------------------------------------------------------------
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        case (i_op_EX)
            c_OP_MUL, c_OP_MULH, c_OP_DIV, c_OP_REM: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
            end
            c_OP_MULHSU: rs1_signed = 1'b1;
            default: ;
        endcase
    end

    assign sign1 = rs1_signed & i_rd1_EX[WIDTH-1];
    assign sign2 = rs2_signed & i_rd2_EX[WIDTH-1];
    assign mag1  = sign1 ? -i_rd1_EX : i_rd1_EX;
    assign mag2  = sign2 ? -i_rd2_EX : i_rd2_EX;

    // Remainder takes the dividend's sign; everything else the XOR of both.
    assign start_neg = (i_op_EX[2] && i_op_EX[1]) ? sign1 : (sign1 ^ sign2);

    assign div_by_zero = i_op_EX[2] && (i_rd2_EX == '0);
    assign div_ovf     = i_op_EX[2] && !i_op_EX[0] &&
                         (i_rd1_EX == c_MIN_NEG) && (i_rd2_EX == '1);
    assign fast_path   = div_by_zero || div_ovf;

    always_comb begin
        fast_result = '0;
        if (div_by_zero) begin
            fast_result = i_op_EX[1] ? i_rd1_EX : '1;
        end else if (div_ovf) begin
            fast_result = i_op_EX[1] ? '0 : i_rd1_EX;
        end
    end

    assign start_ok = i_start_EX && !i_kill_EX &&
                      ((state_q == c_S_IDLE) || (state_q == c_S_DONE));

    // ------------------------------------------------------------------
    // One iteration of each datapath
    // ------------------------------------------------------------------
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
                   (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_step = {mul_sum, acc_q[WIDTH-1:1]};

        // Shifted partial remainder needs one extra bit before the trial subtract.
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opnd_q};
        div_step = div_diff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                   : {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end

    // ------------------------------------------------------------------
    // Sign correction and result select
    // ------------------------------------------------------------------
    assign quot_raw = acc_q[WIDTH-1:0];
    assign rem_raw  = acc_q[2*WIDTH-1:WIDTH];
    assign prod_fix = neg_q ? -acc_q    : acc_q;
    assign quot_fix = neg_q ? -quot_raw : quot_raw;
    assign rem_fix  = neg_q ? -rem_raw  : rem_raw;

    always_comb begin
        fix_result = rem_fix;
        case (op_q)
            c_OP_MUL:                          fix_result = prod_fix[WIDTH-1:0];
            c_OP_MULH, c_OP_MULHSU, c_OP_MULHU: fix_result = prod_fix[2*WIDTH-1:WIDTH];
            c_OP_DIV, c_OP_DIVU:               fix_result = quot_fix;
            default:                           fix_result = rem_fix;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= c_S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_S_IDLE, c_S_DONE: begin
                if (i_start_EX) begin
                    state_d = fast_path ? c_S_DONE : c_S_CALC;
                end else begin
                    state_d = c_S_IDLE;
                end
            end
            c_S_CALC: begin
                if (cnt_q == c_CNT_LAST) begin
                    state_d = c_S_FIX;
                end
            end
            c_S_FIX:  state_d = c_S_DONE;
            default:  state_d = c_S_IDLE;
        endcase
        if (i_kill_EX) begin
            state_d = c_S_IDLE;
        end
    end

    // FSM: outputs
    always_comb begin
        o_busy_EX  = (state_q == c_S_CALC) || (state_q == c_S_FIX);
        o_valid_EX = (state_q == c_S_DONE) && !i_kill_EX;
    end

    assign o_result_EX = result_q;

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        if (i_kill_EX) begin
            cnt_d = '0;
        end else if (start_ok) begin
            op_d  = i_op_EX;
            neg_d = start_neg;
            cnt_d = '0;
            // Divide keeps the dividend in the low half; multiply keeps the multiplier there.
            if (i_op_EX[2]) begin
                acc_d  = {{WIDTH{1'b0}}, mag1};
                opnd_d = mag2;
            end else begin
                acc_d  = {{WIDTH{1'b0}}, mag2};
                opnd_d = mag1;
            end
            if (fast_path) begin
                result_d = fast_result;
            end
        end else if (state_q == c_S_CALC) begin
            acc_d = op_q[2] ? div_step : mul_step;
            cnt_d = (cnt_q == c_CNT_LAST) ? '0 : cnt_q + c_CNT_W'(1);
        end else if (state_q == c_S_FIX) begin
            result_d = fix_result;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M multiply/divide operations, sitting in the EX stage beside the single-cycle ALU.
- Accepts one operation per start pulse and runs a radix-2 shift-add (multiply) or restoring shift-subtract (divide) datapath over WIDTH cycles, then applies sign correction.
- Returns the result with a one-cycle valid pulse.
- The hazard unit stalls the pipeline while o_busy is high.

Parameters:
- WIDTH, 32: operand and result width; the iteration counter spans 0..WIDTH-1.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start_EX  in  1  launch request; sampled only when the block is idle-capable (state IDLE or DONE).
- i_op_EX  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- i_rd1_EX  in  WIDTH  rs1 operand (multiplicand/dividend).
- i_rd2_EX  in  WIDTH  rs2 operand (multiplier/divisor).
- i_kill_EX  in  1  flush; aborts any operation in flight.
- o_busy_EX  out  1  high in CALC and FIX.
- o_valid_EX  out  1  single-cycle result strobe.
- o_result_EX  out  WIDTH  result; holds the last value until the next completion.

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, counter 0, o_busy_EX 0, o_valid_EX 0, o_result_EX 0, all internal operand/accumulator registers 0.
- States and transitions:
  - IDLE → CALC on i_start_EX.
  - IDLE → DONE on i_start_EX with a fast-path condition.
  - CALC → FIX when counter = WIDTH-1.
  - FIX → DONE.
  - DONE → IDLE, or DONE accepts a new i_start_EX exactly as IDLE does.
- Capture on start:
  - Latch op and operand magnitudes; magnitudes are two's-complement absolute values for the signed operands of each op.
  - MULHSU treats only rs1 as signed; MULHU, DIVU and REMU treat both operands as unsigned.
  - Latch the result sign:
    - Multiply: sign1 XOR sign2.
    - DIV: sign1 XOR sign2.
    - REM: sign1.
- CALC, one iteration per cycle, counter increments each cycle:
  - Multiply: 2*WIDTH-bit product accumulator; add the multiplicand when the multiplier LSB is 1, then shift.
  - Divide: 2*WIDTH-bit remainder:quotient register; shift left, trial-subtract the divisor, set quotient bit if the result is non-negative.
- FIX: conditionally negate the product, quotient or remainder, then select the output:
  - MUL: low WIDTH bits.
  - MULH/MULHSU/MULHU: high WIDTH bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
- DONE: o_valid_EX=1 for exactly this cycle; o_result_EX is updated on entry to DONE.
- Latency: the o_valid_EX rising edge is WIDTH+2 cycles after the start edge (34 for WIDTH=32).
- Fast path: latency 1, o_valid_EX the cycle after start, no CALC.
  - Divisor = 0: DIV/DIVU result all-ones; REM/REMU result = rs1.
  - Signed overflow (DIV/REM, rs1 = 1 followed by WIDTH-1 zeros, rs2 = all-ones): DIV result = rs1; REM result = 0.
- i_start_EX while in CALC or FIX: ignored, with no queuing.
- i_kill_EX, any state: next state IDLE, o_valid_EX forced 0 that cycle and the next, o_result_EX unchanged.
- i_kill_EX and i_start_EX in the same cycle: kill wins and the start is dropped.
- Operands change after start: no effect, since they are latched.
- Back-to-back: a start in the DONE cycle begins a new operation with no idle bubble.

Test Plan:
- MUL rd1=7, rd2=0xFFFFFFFD (-3), start at cycle 0 → o_busy_EX high cycles 1-33, o_valid_EX at cycle 34, o_result_EX=0xFFFFFFEB; MULHU on the same operands → 0x00000006.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIVU 100/7 → 0x0000000E; REM 0xFFFFFFF9 (-7) % 2 → 0xFFFFFFFF; DIV -7/2 → 0xFFFFFFFD; each with o_valid_EX at cycle 34.
- DIV 5/0 → 0xFFFFFFFF and REMU 5/0 → 0x00000005, both with o_valid_EX at cycle 1 and o_busy_EX never high; DIV 0x80000000/0xFFFFFFFF → 0x80000000, REM of the same operands → 0, latency 1.
- Start DIVU, assert i_kill_EX at cycle 10 → o_busy_EX low from cycle 11, no o_valid_EX, o_result_EX unchanged; a start at cycle 12 completes normally at cycle 46.
- Assert i_rst_n=0 asynchronously at cycle 20 of a MUL → outputs 0 immediately; a start pulse during CALC is ignored; a start in the DONE cycle yields the next o_valid_EX exactly 34 cycles later.
